// File: rtl/pipe_ctrl_mc_pkg.sv
// pipe_ctrl_mc_pkg: shared types and helpers for the pipeline controller.
//   state_e   : controller FSM states (RUN / WAIT / FLUSH)
//   PC_W      : program-counter width
//   stall_w() : stall-vector width derived from the stage count (PC + stages)
package pipe_ctrl_mc_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam int PC_W = 32;

  function automatic int stall_w(input int num_stages);
    return num_stages + 1;
  endfunction

endpackage

// File: rtl/pipe_ctrl_mc_if.sv
// pipe_ctrl_mc_if: pipeline-side bundle of the controller.
//   stallreq_i  per-stage stall requests (bit i = stage i+1)
//   mem_req_i   MEM stage holds a load/store
//   flush_req_i redirect request, flush_pc_i its target
//   stall_o     hold vector (bit0 = PC), flush_o clear stages, new_pc_o redirect PC
//   mem_ready_o RAM data valid, stall_cnt_o saturating stall-cycle counter
// slave = controller side, master = pipeline side.
interface pipe_ctrl_mc_if
  import pipe_ctrl_mc_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int CNT_W      = 32
);
  logic [NUM_STAGES-1:0] stallreq_i;
  logic                  mem_req_i;
  logic                  flush_req_i;
  logic [PC_W-1:0]       flush_pc_i;
  logic [NUM_STAGES:0]   stall_o;
  logic                  flush_o;
  logic [PC_W-1:0]       new_pc_o;
  logic                  mem_ready_o;
  logic [CNT_W-1:0]      stall_cnt_o;

  modport slave (
    input  stallreq_i, mem_req_i, flush_req_i, flush_pc_i,
    output stall_o, flush_o, new_pc_o, mem_ready_o, stall_cnt_o
  );

  modport master (
    output stallreq_i, mem_req_i, flush_req_i, flush_pc_i,
    input  stall_o, flush_o, new_pc_o, mem_ready_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl_mc_stall_mask_enc.sv
// stall_mask_enc: combinational request -> stall vector encoder.
//   req_i   bit s set = stall PC and stage registers 0..s
//   stall_o bit j = 1 when any request at position >= j is set
// A stall at stage s must also freeze everything upstream of it, so each
// output bit is the OR-reduction of the requests at or above its position.
module stall_mask_enc #(
  parameter int W = 6
) (
  input  logic [W-1:0] req_i,
  output logic [W-1:0] stall_o
);
  for (genvar j = 0; j < W; j++) begin : g_bit
    assign stall_o[j] = |req_i[W-1:j];
  end
endmodule

// File: rtl/pipe_ctrl_mc.sv
// pipe_ctrl_mc: pipeline controller for the in-order MIPS core.
//   clk, rst  clock and synchronous active-high reset
//   bus       pipe_ctrl_mc_if.slave (stall requests, memory access, redirect)
// Merges stage stall requests, inserts MEM_WAIT wait states per data-RAM
// access, and sequences flushes. A flush raised during a wait is held in
// pend_q and issued once the access completes.
module pipe_ctrl_mc
  import pipe_ctrl_mc_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int MEM_STAGE  = 4,
  parameter int MEM_WAIT   = 2,
  parameter int CNT_W      = 32
) (
  input  logic           clk,
  input  logic           rst,
  pipe_ctrl_mc_if.slave  bus
);
  localparam int SW = stall_w(NUM_STAGES);
  // With MEM_WAIT=0 the WAIT state is unreachable and cnt_q stays constant 0,
  // so the register folds away; the 1-bit floor keeps the declaration legal.
  localparam int CW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0] scnt_q;

  logic          mem_stall, all_stall, flush, ready;
  logic [SW-1:0] req, enc_stall, stall;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pc_d      = pc_q;
    mem_stall = 1'b0;
    all_stall = 1'b0;
    flush     = 1'b0;
    ready     = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (bus.flush_req_i) begin
          // redirect wins; a same-cycle access is dropped with the flush
          all_stall = 1'b1;
          pc_d      = bus.flush_pc_i;
          state_d   = ST_FLUSH;
        end else if (bus.mem_req_i) begin
          if (MEM_WAIT > 0) begin
            mem_stall = 1'b1;
            cnt_d     = CW'(MEM_WAIT - 1);
            state_d   = ST_WAIT;
          end else begin
            ready = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (bus.flush_req_i) pc_d = bus.flush_pc_i;
        if (cnt_q != '0) begin
          mem_stall = 1'b1;
          cnt_d     = cnt_q - 1'b1;
          if (bus.flush_req_i) pend_d = 1'b1;
        end else begin
          // last cycle of the access: mem_req_i still belongs to it
          ready   = 1'b1;
          state_d = (pend_q || bus.flush_req_i) ? ST_FLUSH : ST_RUN;
        end
      end
      ST_FLUSH: begin
        flush   = 1'b1;
        pend_d  = 1'b0;
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // request position s freezes PC..stage s; stage i+1 lives at bit i+1
  always_comb begin
    req            = {bus.stallreq_i, 1'b0};
    req[MEM_STAGE] = req[MEM_STAGE] | mem_stall;
    req[SW-1]      = req[SW-1] | all_stall;
  end

  stall_mask_enc #(.W(SW)) u_enc (
    .req_i   (req),
    .stall_o (enc_stall)
  );

  // stages are being cleared during FLUSH, so holding them is meaningless
  assign stall = (state_q == ST_FLUSH) ? '0 : enc_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      pc_q    <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      pc_q    <= pc_d;
      if (stall[0] && (scnt_q != '1)) scnt_q <= scnt_q + 1'b1;
    end
  end

  assign bus.stall_o     = stall;
  assign bus.flush_o     = flush;
  assign bus.new_pc_o    = pc_q;
  assign bus.mem_ready_o = ready;
  assign bus.stall_cnt_o = scnt_q;
endmodule

// File: tb/tb_pipe_ctrl_mc.sv
module tb_pipe_ctrl_mc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl_mc_if #(.NUM_STAGES(5), .CNT_W(32)) if1 ();
  pipe_ctrl_mc_if #(.NUM_STAGES(5), .CNT_W(2))  if2 ();

  pipe_ctrl_mc #(.NUM_STAGES(5), .MEM_STAGE(4), .MEM_WAIT(2), .CNT_W(32)) dut (
    .clk (clk), .rst (rst), .bus (if1.slave)
  );
  pipe_ctrl_mc #(.NUM_STAGES(5), .MEM_STAGE(4), .MEM_WAIT(0), .CNT_W(2)) dut0 (
    .clk (clk), .rst (rst), .bus (if2.slave)
  );

  // ---------------- reference model for dut (MEM_WAIT=2) ----------------
  // Tracks an access by the cycle its data becomes ready rather than by a
  // countdown: stall while cycle < ready_at, ready on cycle == ready_at.
  int          m_cyc = 0;
  bit          m_acc = 0;
  int          m_ready_at = 0;
  bit          m_pend = 0;
  bit          m_flushing = 0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_cnt = '0;

  function automatic logic [5:0] mask(input int s);
    return 6'((1 << (s + 1)) - 1);
  endfunction

  task automatic model_exp(output logic [5:0] st, output logic fl, output logic rd);
    st = '0; fl = 1'b0; rd = 1'b0;
    for (int i = 0; i < 5; i++) if (if1.stallreq_i[i]) st |= mask(i + 1);
    if (m_flushing) begin
      fl = 1'b1; st = '0;
    end else if (m_acc) begin
      if (m_cyc < m_ready_at) st |= mask(4);
      else rd = 1'b1;
    end else if (if1.flush_req_i) begin
      st = '1;
    end else if (if1.mem_req_i) begin
      st |= mask(4);
    end
  endtask

  always @(posedge clk) begin : model
    logic [5:0] st;
    logic fl, rd;
    model_exp(st, fl, rd);
    if (rst) begin
      m_acc = 0; m_pend = 0; m_flushing = 0; m_pc = '0; m_cnt = '0;
    end else begin
      if (st[0] && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (m_flushing) begin
        m_flushing = 0; m_pend = 0;
      end else if (m_acc) begin
        if (if1.flush_req_i) m_pc = if1.flush_pc_i;
        if (m_cyc < m_ready_at) begin
          if (if1.flush_req_i) m_pend = 1;
        end else begin
          m_flushing = m_pend || if1.flush_req_i;
          m_acc = 0;
        end
      end else if (if1.flush_req_i) begin
        m_pc = if1.flush_pc_i; m_flushing = 1;
      end else if (if1.mem_req_i) begin
        m_acc = 1; m_ready_at = m_cyc + 2;
      end
    end
    m_cyc++;
  end

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    if1.stallreq_i = '0; if1.mem_req_i = 1'b0; if1.flush_req_i = 1'b0; if1.flush_pc_i = '0;
    if2.stallreq_i = '0; if2.mem_req_i = 1'b0; if2.flush_req_i = 1'b0; if2.flush_pc_i = '0;
  endtask

  // ---------------- directed tests ----------------
  task automatic test_reset();
    rst = 1'b1; idle_inputs();
    next_cycle(); next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (if1.stall_o !== 6'b0 || if1.flush_o !== 1'b0 || if1.mem_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outs stall=%b flush=%b rdy=%b exp 0/0/0", if1.stall_o, if1.flush_o, if1.mem_ready_o);
    end
    checks++;
    if (if1.new_pc_o !== 32'h0 || if1.stall_cnt_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_regs new_pc=%h cnt=%0d exp 0/0", if1.new_pc_o, if1.stall_cnt_o);
    end
    next_cycle();
  endtask

  task automatic test_id_stall();
    // starts right after reset: counter at 0
    for (int k = 0; k < 3; k++) begin
      if1.stallreq_i = 5'b00010;
      @(negedge clk);
      checks++;
      if (if1.stall_o !== 6'b000111 || if1.stall_cnt_o !== 32'(k)) begin
        errors++;
        $display("FAIL id_stall k=%0d stall=%b cnt=%0d exp 000111/%0d", k, if1.stall_o, if1.stall_cnt_o, k);
      end
      next_cycle();
    end
    if1.stallreq_i = '0;
    @(negedge clk);
    checks++;
    if (if1.stall_o !== 6'b0 || if1.stall_cnt_o !== 32'd3) begin
      errors++;
      $display("FAIL id_stall_end stall=%b cnt=%0d exp 000000/3", if1.stall_o, if1.stall_cnt_o);
    end
    next_cycle();
  endtask

  task automatic test_mem_wait();
    logic [5:0] es [3];
    es = '{6'b011111, 6'b011111, 6'b000000};
    if1.mem_req_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (if1.stall_o !== es[k] || if1.mem_ready_o !== (k == 2)) begin
        errors++;
        $display("FAIL mem_wait t+%0d stall=%b rdy=%b exp %b/%0d", k, if1.stall_o, if1.mem_ready_o, es[k], k == 2);
      end
      next_cycle();
    end
    if1.mem_req_i = 1'b0;
    next_cycle();
  endtask

  task automatic test_flush();
    if1.flush_req_i = 1'b1; if1.flush_pc_i = 32'hBFC00380;
    @(negedge clk);
    checks++;
    if (if1.stall_o !== 6'b111111 || if1.flush_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_t stall=%b flush=%b exp 111111/0", if1.stall_o, if1.flush_o);
    end
    next_cycle();
    if1.flush_req_i = 1'b0; if1.flush_pc_i = '0;
    if1.stallreq_i = 5'b11111;  // masked while flushing
    @(negedge clk);
    checks++;
    if (if1.flush_o !== 1'b1 || if1.new_pc_o !== 32'hBFC00380 || if1.stall_o !== 6'b0) begin
      errors++;
      $display("FAIL flush_t1 flush=%b pc=%h stall=%b exp 1/bfc00380/000000", if1.flush_o, if1.new_pc_o, if1.stall_o);
    end
    next_cycle();
    if1.stallreq_i = '0;
    @(negedge clk);
    checks++;
    if (if1.flush_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_t2 flush=%b exp 0", if1.flush_o);
    end
    next_cycle();
  endtask

  task automatic test_deferred_flush();
    if1.mem_req_i = 1'b1;
    next_cycle();                                  // t+1
    if1.flush_req_i = 1'b1; if1.flush_pc_i = 32'h8000_0180;
    @(negedge clk);
    checks++;
    if (if1.flush_o !== 1'b0 || if1.stall_o !== 6'b011111) begin
      errors++;
      $display("FAIL defer_t1 flush=%b stall=%b exp 0/011111", if1.flush_o, if1.stall_o);
    end
    next_cycle();                                  // t+2
    if1.flush_req_i = 1'b0; if1.flush_pc_i = '0;
    @(negedge clk);
    checks++;
    if (if1.flush_o !== 1'b0 || if1.mem_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL defer_t2 flush=%b rdy=%b exp 0/1", if1.flush_o, if1.mem_ready_o);
    end
    next_cycle();                                  // t+3
    if1.mem_req_i = 1'b0;
    @(negedge clk);
    checks++;
    if (if1.flush_o !== 1'b1 || if1.new_pc_o !== 32'h8000_0180) begin
      errors++;
      $display("FAIL defer_t3 flush=%b pc=%h exp 1/80000180", if1.flush_o, if1.new_pc_o);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_wait();
    if1.stallreq_i = 5'b00001;
    if1.mem_req_i = 1'b1;
    next_cycle();                                  // t+1
    rst = 1'b1; if1.mem_req_i = 1'b0; if1.stallreq_i = '0;
    next_cycle();                                  // t+2
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (if1.stall_o !== 6'b0 || if1.mem_ready_o !== 1'b0 || if1.flush_o !== 1'b0 ||
        if1.stall_cnt_o !== 32'h0 || if1.new_pc_o !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid stall=%b rdy=%b flush=%b cnt=%0d pc=%h exp all 0",
               if1.stall_o, if1.mem_ready_o, if1.flush_o, if1.stall_cnt_o, if1.new_pc_o);
    end
    next_cycle();
  endtask

  task automatic test_random();
    logic [5:0] st;
    logic fl, rd;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 5; i++) if1.stallreq_i[i] = ($urandom_range(0, 9) == 0);
      if1.mem_req_i   = ($urandom_range(0, 9) < 3);
      if1.flush_req_i = ($urandom_range(0, 11) == 0);
      if1.flush_pc_i  = $urandom;
      @(negedge clk);
      model_exp(st, fl, rd);
      checks++;
      if (if1.stall_o !== st || if1.flush_o !== fl || if1.mem_ready_o !== rd ||
          if1.new_pc_o !== m_pc || if1.stall_cnt_o !== m_cnt) begin
        errors++;
        $display("FAIL random n=%0d stall=%b/%b flush=%b/%b rdy=%b/%b pc=%h/%h cnt=%0d/%0d (got/exp)",
                 n, if1.stall_o, st, if1.flush_o, fl, if1.mem_ready_o, rd,
                 if1.new_pc_o, m_pc, if1.stall_cnt_o, m_cnt);
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_nowait_sat();
    // dut0 saw no stall since the last reset: counter starts at 0
    for (int k = 0; k < 5; k++) begin
      if2.stallreq_i = 5'b00001;
      if2.mem_req_i  = (k != 1);
      @(negedge clk);
      checks++;
      if (if2.stall_o !== 6'b000011 || if2.mem_ready_o !== if2.mem_req_i ||
          if2.stall_cnt_o !== 2'((k > 3) ? 3 : k)) begin
        errors++;
        $display("FAIL nowait k=%0d stall=%b rdy=%b cnt=%0d exp 000011/%b/%0d",
                 k, if2.stall_o, if2.mem_ready_o, if2.stall_cnt_o, if2.mem_req_i, (k > 3) ? 3 : k);
      end
      next_cycle();
    end
    if2.stallreq_i = '0; if2.mem_req_i = 1'b1;
    @(negedge clk);
    checks++;
    if (if2.stall_o !== 6'b0 || if2.mem_ready_o !== 1'b1 || if2.stall_cnt_o !== 2'b11) begin
      errors++;
      $display("FAIL nowait_sat stall=%b rdy=%b cnt=%b exp 000000/1/11", if2.stall_o, if2.mem_ready_o, if2.stall_cnt_o);
    end
    next_cycle();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_id_stall();
    test_mem_wait();
    test_flush();
    test_deferred_flush();
    test_reset_mid_wait();
    test_random();
    test_nowait_sat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
